// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: table geometry, PC bit
// positions, counter init value, FSM states and the registered prediction.
package branch_predictor_pkg;
    localparam int SIZE_PC       = 32;
    localparam int PHT_DEPTH_DEF = 256;
    localparam int BTB_DEPTH_DEF = 64;
    localparam int TAG_W_DEF     = 8;
    localparam int PHT_IDX_LSB   = 2;
    localparam int BTB_IDX_LSB   = 2;
    localparam int TAG_LSB       = 8;
    localparam int PC_STEP       = 8;

    localparam logic [1:0] CTR_INIT = 2'b01;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic               vld;
        logic               dir;
        logic               hit;
        logic [SIZE_PC-1:0] target;
    } pred_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction
endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: direct-mapped storage with combinational tag compare
// and a single synchronous write port. Storage is cleared only by the owner.
module bp_btb #(
    parameter int DEPTH = 64,
    parameter int IW    = 6,
    parameter int TAG_W = 8,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic [IW-1:0]    rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             hit_o,
    output logic             cond_o,
    output logic [PC_W-1:0]  target_o,
    input  logic             we_i,
    input  logic [IW-1:0]    wr_idx_i,
    input  logic             wr_valid_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_cond_i,
    input  logic [PC_W-1:0]  wr_target_i
);
    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic             cond_q   [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            valid_q[wr_idx_i]  <= wr_valid_i;
            tag_q[wr_idx_i]    <= wr_tag_i;
            cond_q[wr_idx_i]   <= wr_cond_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    // Reads see the contents before this cycle's write lands.
    assign hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign cond_o   = cond_q[rd_idx_i];
    assign target_o = target_q[rd_idx_i];
endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter PHT plus BTB, one-cycle lookup,
// with an INIT sweep that initialises both tables after every reset.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PHT_DEPTH = PHT_DEPTH_DEF,
    parameter int BTB_DEPTH = BTB_DEPTH_DEF,
    parameter int TAG_W     = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fetchValid_i,
    input  logic [SIZE_PC-1:0] fetchPC_i,
    input  logic               flush_i,
    output logic               predValid_o,
    output logic               predDir_o,
    output logic [SIZE_PC-1:0] predTarget_o,
    output logic               btbHit_o,
    input  logic               updValid_i,
    input  logic [SIZE_PC-1:0] updPC_i,
    input  logic               updCond_i,
    input  logic               updDir_i,
    input  logic [SIZE_PC-1:0] updTarget_i,
    output logic               ready_o
);
    localparam int PHT_IW = $clog2(PHT_DEPTH);
    localparam int BTB_IW = $clog2(BTB_DEPTH);
    localparam logic [PHT_IW:0] IDX_END = (PHT_IW+1)'(PHT_DEPTH);
    localparam logic [PHT_IW:0] BTB_END = (PHT_IW+1)'(BTB_DEPTH);
    localparam logic [PHT_IW:0] IDX_ONE = (PHT_IW+1)'(1);

    bp_state_e       state_q, state_d;
    logic [PHT_IW:0] idx_q, idx_d;
    pred_t           pred_q, pred_d;
    logic [1:0]      pht_q [PHT_DEPTH];

    logic              run, init_wr;
    logic [PHT_IW-1:0] f_pht_idx, u_pht_idx;
    logic [BTB_IW-1:0] f_btb_idx, u_btb_idx;
    logic [SIZE_PC-1:0] pc_plus8;

    logic               btb_hit, btb_cond;
    logic [SIZE_PC-1:0] btb_target;
    logic               btb_we, btb_wr_valid;
    logic [BTB_IW-1:0]  btb_wr_idx;
    logic               unused_upd_pc;

    assign run       = (state_q == ST_RUN);
    assign init_wr   = !run && (idx_q < IDX_END);
    assign f_pht_idx = fetchPC_i[PHT_IDX_LSB +: PHT_IW];
    assign u_pht_idx = updPC_i[PHT_IDX_LSB +: PHT_IW];
    assign f_btb_idx = fetchPC_i[BTB_IDX_LSB +: BTB_IW];
    assign u_btb_idx = updPC_i[BTB_IDX_LSB +: BTB_IW];
    assign pc_plus8  = fetchPC_i + SIZE_PC'(PC_STEP);
    assign unused_upd_pc = ^updPC_i;

    // One extra cycle after the last index so ready rises PHT_DEPTH+1 cycles out.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_INIT: begin
                if (idx_q == IDX_END) state_d = ST_RUN;
                else                  idx_d   = idx_q + IDX_ONE;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            pred_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pred_q  <= pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (init_wr)
            pht_q[idx_q[PHT_IW-1:0]] <= CTR_INIT;
        else if (run && updValid_i && updCond_i)
            pht_q[u_pht_idx] <= ctr_next(pht_q[u_pht_idx], updDir_i);
    end

    always_comb begin
        btb_we       = 1'b0;
        btb_wr_idx   = u_btb_idx;
        btb_wr_valid = 1'b1;
        if (init_wr) begin
            btb_we       = (idx_q < BTB_END);
            btb_wr_idx   = idx_q[BTB_IW-1:0];
            btb_wr_valid = 1'b0;
        end else if (run && updValid_i) begin
            btb_we = updDir_i || !updCond_i;
        end
    end

    bp_btb #(
        .DEPTH (BTB_DEPTH),
        .IW    (BTB_IW),
        .TAG_W (TAG_W),
        .PC_W  (SIZE_PC)
    ) u_btb (
        .clk         (clk),
        .rd_idx_i    (f_btb_idx),
        .rd_tag_i    (fetchPC_i[TAG_LSB +: TAG_W]),
        .hit_o       (btb_hit),
        .cond_o      (btb_cond),
        .target_o    (btb_target),
        .we_i        (btb_we),
        .wr_idx_i    (btb_wr_idx),
        .wr_valid_i  (btb_wr_valid),
        .wr_tag_i    (updPC_i[TAG_LSB +: TAG_W]),
        .wr_cond_i   (updCond_i),
        .wr_target_i (updTarget_i)
    );

    always_comb begin
        pred_d = '0;
        if (fetchValid_i && run) begin
            pred_d.vld    = 1'b1;
            pred_d.hit    = btb_hit;
            pred_d.target = pc_plus8;
            if (btb_hit) begin
                pred_d.dir = btb_cond ? pht_q[f_pht_idx][1] : 1'b1;
                if (pred_d.dir) pred_d.target = btb_target;
            end
        end
    end

    // Flush kills the in-flight prediction combinationally; all fields zero when invalid.
    assign predValid_o  = pred_q.vld && !flush_i;
    assign predDir_o    = pred_q.dir && predValid_o;
    assign btbHit_o     = pred_q.hit && predValid_o;
    assign predTarget_o = predValid_o ? pred_q.target : '0;
    assign ready_o      = run;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference model pushes the expected
// prediction when a lookup is driven; it is popped and compared a cycle later.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetchValid_i = 1'b0;
    logic [31:0] fetchPC_i = '0;
    logic        flush_i = 1'b0;
    logic        predValid_o, predDir_o, btbHit_o, ready_o;
    logic [31:0] predTarget_o;
    logic        updValid_i = 1'b0;
    logic [31:0] updPC_i = '0;
    logic        updCond_i = 1'b0;
    logic        updDir_i = 1'b0;
    logic [31:0] updTarget_i = '0;

    branch_predictor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetchValid_i (fetchValid_i),
        .fetchPC_i    (fetchPC_i),
        .flush_i      (flush_i),
        .predValid_o  (predValid_o),
        .predDir_o    (predDir_o),
        .predTarget_o (predTarget_o),
        .btbHit_o     (btbHit_o),
        .updValid_i   (updValid_i),
        .updPC_i      (updPC_i),
        .updCond_i    (updCond_i),
        .updDir_i     (updDir_i),
        .updTarget_i  (updTarget_i),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        vld;
        bit        dir;
        bit        hit;
        bit [31:0] tgt;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "reset";

    bit [1:0]  pht_m [256];
    bit        v_m   [64];
    bit [7:0]  tag_m [64];
    bit        c_m   [64];
    bit [31:0] t_m   [64];
    bit        model_run = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", phase, tag, act, exp);
        end
    endtask

    function automatic exp_t predict(input bit v, input logic [31:0] pc);
        exp_t e;
        int   bi;
        bit   hit;
        e = '0;
        if (!v) return e;
        bi    = int'(pc[7:2]);
        hit   = v_m[bi] && (tag_m[bi] == pc[15:8]);
        e.vld = 1'b1;
        e.hit = hit;
        e.tgt = pc + 32'd8;
        if (hit && (!c_m[bi] || pht_m[pc[9:2]][1])) begin
            e.dir = 1'b1;
            e.tgt = t_m[bi];
        end
        return e;
    endfunction

    task automatic model_update(input logic [31:0] pc, input bit uc, input bit ud, input logic [31:0] tgt);
        int pi, bi;
        pi = int'(pc[9:2]);
        bi = int'(pc[7:2]);
        if (uc) begin
            if (ud) pht_m[pi] = (pht_m[pi] == 2'b11) ? 2'b11 : pht_m[pi] + 2'b01;
            else    pht_m[pi] = (pht_m[pi] == 2'b00) ? 2'b00 : pht_m[pi] - 2'b01;
        end
        if (ud || !uc) begin
            v_m[bi]   = 1'b1;
            tag_m[bi] = pc[15:8];
            c_m[bi]   = uc;
            t_m[bi]   = tgt;
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 256; i++) pht_m[i] = 2'b01;
        for (int i = 0; i < 64; i++) v_m[i] = 1'b0;
    endtask

    task automatic step(input bit fv, input logic [31:0] fpc, input bit fl,
                        input bit uv, input logic [31:0] upc, input bit uc,
                        input bit ud, input logic [31:0] ut);
        exp_t e;
        @(negedge clk);
        fetchValid_i = fv; fetchPC_i = fpc; flush_i = fl;
        updValid_i = uv; updPC_i = upc; updCond_i = uc; updDir_i = ud; updTarget_i = ut;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (fl) e = '0;
            chk("vld", predValid_o, e.vld);
            chk("dir", predDir_o, e.dir);
            chk("hit", btbHit_o, e.hit);
            chk("tgt", predTarget_o, e.tgt);
        end
        sb.push_back(predict(fv && model_run, fpc));
        if (uv && model_run) model_update(upc, uc, ud, ut);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit uc, input bit ud, input logic [31:0] tgt);
        step(1'b0, '0, 1'b0, 1'b1, pc, uc, ud, tgt);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Releases reset and times the sweep; lookups (and optionally updates)
    // are held active throughout and must have no effect.
    task automatic init_seq(input bit drive_upd);
        int cnt;
        bit saw;
        @(negedge clk);
        fetchValid_i = 1'b1; fetchPC_i = 32'h0040_0100; flush_i = 1'b0;
        updValid_i = drive_upd; updPC_i = 32'h0040_0300; updCond_i = 1'b0;
        updDir_i = 1'b1; updTarget_i = 32'h0000_1234;
        reset_n = 1'b1;
        cnt = 0;
        saw = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (predValid_o) saw = 1'b1;
            if (ready_o) break;
        end
        chk("ready_lat", cnt, 257);
        chk("init_vld", saw, 1'b0);
        fetchValid_i = 1'b0;
        updValid_i   = 1'b0;
        model_init();
        model_run = 1'b1;
        sb.delete();
    endtask

    task automatic chk_zero();
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_vld", predValid_o, 1'b0);
        chk("rst_dir", predDir_o, 1'b0);
        chk("rst_hit", btbHit_o, 1'b0);
        chk("rst_tgt", predTarget_o, 32'h0);
    endtask

    initial begin
        logic [31:0] pcs [7];
        pcs = '{32'h0040_0100, 32'h0040_0104, 32'h0040_0200, 32'h0040_1200,
                32'h0040_0300, 32'hFFFF_FFFC, 32'h0041_0100};

        #3;
        chk_zero();
        #20;
        phase = "init";
        init_seq(1'b0);

        phase = "miss";
        look(32'h0040_0100);
        idle();

        phase = "cond_taken";
        upd(32'h0040_0100, 1'b1, 1'b1, 32'h0040_0040);
        upd(32'h0040_0100, 1'b1, 1'b1, 32'h0040_0040);
        look(32'h0040_0100);
        idle();

        // Four not-taken leave the counter at 00; one taken then only reaches 01.
        phase = "cond_sat";
        for (int i = 0; i < 4; i++) upd(32'h0040_0100, 1'b1, 1'b0, 32'h0);
        look(32'h0040_0100);
        upd(32'h0040_0100, 1'b1, 1'b1, 32'h0040_0040);
        look(32'h0040_0100);
        idle();

        // Tag is PC[15:8]; 0x00401200 shares the BTB index but not the tag.
        phase = "uncond";
        upd(32'h0040_0200, 1'b0, 1'b1, 32'h0040_1000);
        look(32'h0040_0200);
        look(32'h0040_1200);
        idle();

        phase = "rbw";
        step(1'b1, 32'h0040_0100, 1'b0, 1'b1, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0040);
        look(32'h0040_0100);
        idle();

        phase = "wrap";
        look(32'hFFFF_FFFC);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        look(32'hFFFF_FFFC);
        idle();

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 6)],
                 ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 6)],
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC);
        end
        idle();

        phase = "midrun_rst";
        look(32'h0040_0200);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero();
        model_run = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        phase = "reinit";
        init_seq(1'b1);

        phase = "after_reinit";
        look(32'h0040_0300);
        look(32'h0040_0200);
        look(32'h0040_0100);
        upd(32'h0040_0100, 1'b1, 1'b1, 32'h0040_0080);
        look(32'h0040_0100);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
